// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
  } de_reg_d;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port plus the decode/execute control and output signals.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_rden;
  logic [31:0] imem_data;
  de_reg_d     de_reg;
  logic [31:0] ir;
  logic        de_valid;

  modport mst (
    input  stall, redirect_valid, redirect_pc, imem_data,
    output imem_addr, imem_rden, de_reg, ir, de_valid
  );

  modport slv (
    output stall, redirect_valid, redirect_pc, imem_data,
    input  imem_addr, imem_rden, de_reg, ir, de_valid
  );

endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC register with next-PC selection: redirect target, sequential +4, or hold.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        advance,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_f
);

  logic [31:0] pc_f_q;
  logic [31:0] pc_f_d;

  always_comb begin
    pc_f_d = pc_f_q;
    if (redirect_valid) begin
      // word-align the target so pc_f[1:0] stays 00
      pc_f_d = redirect_pc & ~32'h3;
    end else if (advance) begin
      pc_f_d = pc_f_q + 32'd4;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_f_q <= RESET_VEC;
    end else begin
      pc_f_q <= pc_f_d;
    end
  end

  assign pc_f = pc_f_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the 1-cycle synchronous imem, tracks the in-flight word,
// and holds it in ir_hold while decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_VEC = fetch_stage_pkg::RESET_VEC,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  fetch_stage_if.mst  bus
);
  import fetch_stage_pkg::*;

  // state | meaning
  // BOOT  | after reset or redirect; nothing valid in flight, stall ignored
  // RUN   | imem_data carries the word for pc_de
  // HOLD  | decode stalled; ir_hold owns the output

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_de_q, pc_de_d;
  logic         v_d_q, v_d_d;
  logic [31:0]  ir_hold_q, ir_hold_d;
  logic [31:0]  pc_f;
  logic         stall_eff;
  logic         advance;

  assign stall_eff = bus.stall && (state_q != BOOT);
  assign advance   = !bus.redirect_valid && !stall_eff;

  fetch_pc_gen #(
    .RESET_VEC (RESET_VEC)
  ) u_pc_gen (
    .CLK            (CLK),
    .RST            (RST),
    .advance        (advance),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .pc_f           (pc_f)
  );

  always_comb begin
    state_d   = state_q;
    pc_de_d   = pc_de_q;
    v_d_d     = v_d_q;
    ir_hold_d = ir_hold_q;
    if (bus.redirect_valid) begin
      v_d_d     = 1'b0;
      state_d   = BOOT;
      ir_hold_d = NOP_INSTR;
    end else if (stall_eff) begin
      // capture only on the first stall cycle; imem is not read while stalled
      if (state_q == RUN) begin
        ir_hold_d = bus.imem_data;
        state_d   = HOLD;
      end
    end else begin
      pc_de_d = pc_f;
      v_d_d   = 1'b1;
      state_d = RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= BOOT;
      pc_de_q   <= 32'h0000_0000;
      v_d_q     <= 1'b0;
      ir_hold_q <= NOP_INSTR;
    end else begin
      state_q   <= state_d;
      pc_de_q   <= pc_de_d;
      v_d_q     <= v_d_d;
      ir_hold_q <= ir_hold_d;
    end
  end

  assign bus.imem_addr = pc_f;
  assign bus.imem_rden = !stall_eff || bus.redirect_valid;
  assign bus.de_valid  = v_d_q;
  assign bus.de_reg.pc = pc_de_q;
  assign bus.ir        = !v_d_q ? NOP_INSTR :
                         ((state_q == HOLD) ? ir_hold_q : bus.imem_data);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem word at byte address a is a>>2; unread cycles return 0xDEADBEEF.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  fetch_stage_if bus ();

  fetch_stage u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_ff @(posedge CLK) begin
    if (bus.imem_rden) begin
      bus.imem_data <= {2'b00, bus.imem_addr[31:2]};
    end else begin
      bus.imem_data <= 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_de(input string tag, input logic v, input logic [31:0] ir,
                        input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, bus.de_valid}, {31'd0, v});
    chk({tag, ".ir"}, bus.ir, ir);
    chk({tag, ".pc"}, bus.de_reg.pc, pc);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    repeat (2) tick();

    // reset state, first cycle with RST low
    RST = 1'b0;
    #1;
    chk_de("rst", 1'b0, 32'h13, 32'h0);
    chk("rst.addr", bus.imem_addr, 32'h0);
    chk("rst.rden", {31'd0, bus.imem_rden}, 32'd1);

    // free-run
    tick(); chk_de("run0", 1'b1, 32'd0, 32'h0);
    tick(); chk_de("run1", 1'b1, 32'd1, 32'h4);
    tick(); chk_de("run2", 1'b1, 32'd2, 32'h8);
    chk("run2.addr", bus.imem_addr, 32'hC);

    // 3-cycle stall with word@0x8 on ir
    bus.stall = 1'b1;
    #1;
    chk("stl0.rden", {31'd0, bus.imem_rden}, 32'd0);
    chk_de("stl0", 1'b1, 32'd2, 32'h8);
    tick(); chk_de("stl1", 1'b1, 32'd2, 32'h8);
    tick(); chk_de("stl2", 1'b1, 32'd2, 32'h8);
    tick();
    bus.stall = 1'b0;
    #1;
    chk_de("stlrel", 1'b1, 32'd2, 32'h8);
    chk("stlrel.rden", {31'd0, bus.imem_rden}, 32'd1);
    tick(); chk_de("post0", 1'b1, 32'd3, 32'hC);
    tick(); chk_de("post1", 1'b1, 32'd4, 32'h10);

    // redirect to 0x103 -> 0x100 after one bubble
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h103;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk_de("rdbub", 1'b0, 32'h13, 32'h10);
    chk("rdbub.addr", bus.imem_addr, 32'h100);
    tick(); chk_de("rdtgt", 1'b1, 32'h40, 32'h100);
    tick(); chk_de("rdtgt1", 1'b1, 32'h41, 32'h104);

    // enter HOLD, then redirect together with stall
    bus.stall = 1'b1;
    tick();
    chk_de("hold", 1'b1, 32'h41, 32'h104);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    #1;
    chk("rdstl.rden", {31'd0, bus.imem_rden}, 32'd1);
    tick();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk("rdstl.bub.valid", {31'd0, bus.de_valid}, 32'd0);
    chk("rdstl.bub.ir", bus.ir, 32'h13);
    tick(); chk_de("rdstl.tgt", 1'b1, 32'h80, 32'h200);

    // wrap-around; stall in the BOOT bubble is ignored
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b1;
    #1;
    chk("boot.stall.rden", {31'd0, bus.imem_rden}, 32'd1);
    chk("boot.valid", {31'd0, bus.de_valid}, 32'd0);
    tick();
    bus.stall = 1'b0;
    #1;
    chk_de("wrap0", 1'b1, 32'h3FFF_FFFF, 32'hFFFF_FFFC);
    chk("wrap0.addr", bus.imem_addr, 32'h0);
    tick(); chk_de("wrap1", 1'b1, 32'd0, 32'h0);
    tick(); chk_de("wrap2", 1'b1, 32'd1, 32'h4);

    // reset asserted while stalled in HOLD
    bus.stall = 1'b1;
    tick();
    chk_de("rsthold", 1'b1, 32'd1, 32'h4);
    RST = 1'b1;
    tick();
    #1;
    chk_de("rststl", 1'b0, 32'h13, 32'h0);
    chk("rststl.addr", bus.imem_addr, 32'h0);
    RST = 1'b0;
    tick(); chk_de("rststl.run", 1'b1, 32'd0, 32'h0);
    bus.stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
